// File: rtl/cnt_data_gen.sv
// cnt_data_gen: multi-mode numeric source for the seven-segment display path.
// A programmable tick advances a value that counts up, down, bounces between
// 0 and DATA_MAX, or sweeps a signed range -DATA_MAX..+DATA_MAX.
module cnt_data_gen #(
  parameter logic [22:0] CNT_TICK = 23'd4_999_999,
  parameter logic [19:0] DATA_MAX = 20'd999_999,
  parameter logic [19:0] STEP     = 20'd1,
  parameter logic [5:0]  POINT    = 6'b000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  mode,
  input  logic        pause,
  input  logic        clear,
  output logic [19:0] data,
  output logic        sign,
  output logic [5:0]  point,
  output logic        seg_en,
  output logic        upd
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_SWEEP  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [22:0] cnt_q, cnt_d;
  mode_e       mode_q, mode_d;
  dir_e        dir_q, dir_d;
  logic [19:0] data_q, data_d;
  logic        sign_q, sign_d;
  logic        upd_q, upd_d;
  logic [5:0]  point_q, point_d;
  logic        seg_en_q, seg_en_d;

  mode_e       mode_in;
  logic        tick;
  logic [20:0] sum;
  logic [19:0] step_data;
  logic        step_sign;
  dir_e        step_dir;
  logic [19:0] start_data;
  logic        start_sign;

  assign mode_in = mode_e'(mode);
  assign tick    = (cnt_q == CNT_TICK);
  assign sum     = {1'b0, data_q} + {1'b0, STEP};

  // Start value of the requested mode, used by clear and by a mode switch.
  always_comb begin
    start_data = '0;
    start_sign = 1'b0;
    if (mode_in == MODE_DOWN || mode_in == MODE_SWEEP) start_data = DATA_MAX;
    if (mode_in == MODE_SWEEP) start_sign = 1'b1;
  end

  // Next value when the mode in force is unchanged at an update edge.
  always_comb begin
    step_data = data_q;
    step_sign = 1'b0;
    step_dir  = dir_q;
    case (mode_q)
      MODE_UP: begin
        step_data = (sum > {1'b0, DATA_MAX}) ? 20'd0 : sum[19:0];
      end
      MODE_DOWN: begin
        step_data = (data_q < STEP) ? DATA_MAX : data_q - STEP;
      end
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (sum >= {1'b0, DATA_MAX}) begin
            step_data = DATA_MAX;
            step_dir  = DIR_DOWN;
          end else begin
            step_data = sum[19:0];
          end
        end else begin
          if (data_q <= STEP) begin
            step_data = '0;
            step_dir  = DIR_UP;
          end else begin
            step_data = data_q - STEP;
          end
        end
      end
      MODE_SWEEP: begin
        // Negative values move toward zero; crossing zero flips to positive and
        // an exact zero always comes out with sign clear.
        if (!sign_q) begin
          if (sum > {1'b0, DATA_MAX}) begin
            step_data = DATA_MAX;
            step_sign = 1'b1;
          end else begin
            step_data = sum[19:0];
          end
        end else begin
          if (data_q > STEP) begin
            step_data = data_q - STEP;
            step_sign = 1'b1;
          end else begin
            step_data = STEP - data_q;
          end
        end
      end
      default: begin
        step_data = data_q;
      end
    endcase
  end

  // Tick counter, mode tracking and value update; clear wins over pause and tick.
  always_comb begin
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    data_d   = data_q;
    sign_d   = sign_q;
    upd_d    = 1'b0;
    point_d  = POINT;
    seg_en_d = 1'b1;
    if (clear) begin
      cnt_d  = '0;
      mode_d = mode_in;
      dir_d  = DIR_UP;
      data_d = start_data;
      sign_d = start_sign;
      upd_d  = 1'b1;
    end else if (!pause) begin
      if (tick) begin
        cnt_d = '0;
        upd_d = 1'b1;
        if (mode_in != mode_q) begin
          mode_d = mode_in;
          dir_d  = DIR_UP;
          data_d = start_data;
          sign_d = start_sign;
        end else begin
          dir_d  = step_dir;
          data_d = step_data;
          sign_d = step_sign;
        end
      end else begin
        cnt_d = cnt_q + 23'd1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q    <= '0;
      mode_q   <= MODE_UP;
      dir_q    <= DIR_UP;
      data_q   <= '0;
      sign_q   <= 1'b0;
      upd_q    <= 1'b0;
      point_q  <= '0;
      seg_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      data_q   <= data_d;
      sign_q   <= sign_d;
      upd_q    <= upd_d;
      point_q  <= point_d;
      seg_en_q <= seg_en_d;
    end
  end

  assign data   = data_q;
  assign sign   = sign_q;
  assign point  = point_q;
  assign seg_en = seg_en_q;
  assign upd    = upd_q;

endmodule
